// File: rtl/matmul_engine.sv
// Tiled matrix multiplier: C[MxN] = A[MxK] * B[KxN], one output row by LANES columns per tile.
// Operands stream from an external memory with one-cycle read latency.
//
//  state | meaning
//  IDLE  | waiting for start, dimensions latched on acceptance
//  ISSUE | one operand read per cycle, k = 0..inner-1
//  LAST  | absorb the final data beat, no read
//  WRITE | present the result tile until wr_ready
//  DONE  | one-cycle done pulse, then back to IDLE
module matmul_engine #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int DIM_W  = 5
) (
  input  logic                     CLOCK_25,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DIM_W-1:0]         rows,
  input  logic [DIM_W-1:0]         inner,
  input  logic [DIM_W-1:0]         cols,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [DIM_W-1:0]         a_row,
  output logic [DIM_W-1:0]         a_col,
  output logic [DIM_W-1:0]         b_row,
  output logic [DIM_W-1:0]         b_col,
  input  logic [DATA_W-1:0]        a_data,
  input  logic [LANES*DATA_W-1:0]  b_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [DIM_W-1:0]         wr_row,
  output logic [DIM_W-1:0]         wr_col,
  output logic [LANES-1:0]         wr_mask,
  output logic [LANES*ACC_W-1:0]   wr_data
);

  localparam int PW = (DATA_W > ACC_W) ? DATA_W : ACC_W;

  typedef enum logic [2:0] {IDLE, ISSUE, LAST, WRITE, DONE} state_t;

  state_t             state;
  logic [DIM_W-1:0]   rows_q, inner_q, cols_q;
  logic [DIM_W-1:0]   r_q, c_q, k_q;
  logic               d_vld, d_first;
  logic [ACC_W-1:0]   acc [LANES];
  logic [PW-1:0]      prod [LANES];
  logic [LANES-1:0]   mask_nxt;
  logic [DIM_W:0]     c_adv;
  logic               last_k, last_row;

  assign a_row  = r_q;
  assign a_col  = k_q;
  assign b_row  = k_q;
  assign b_col  = c_q;
  assign wr_row = r_q;
  assign wr_col = c_q;

  // One extra bit so c + LANES cannot wrap past cols
  assign c_adv    = {1'b0, c_q} + (DIM_W+1)'(LANES);
  assign last_k   = (k_q == inner_q - DIM_W'(1));
  assign last_row = ((r_q + DIM_W'(1)) == rows_q);

  always_comb begin
    mask_nxt = '0;
    for (int i = 0; i < LANES; i++)
      mask_nxt[i] = (({1'b0, c_q} + (DIM_W+1)'(i)) < {1'b0, cols_q});
  end

  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod[i] = PW'(a_data) * PW'(b_data[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      wr_valid <= 1'b0;
      wr_mask  <= '0;
      rows_q   <= '0;
      inner_q  <= '0;
      cols_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      d_vld    <= 1'b0;
      d_first  <= 1'b0;
    end else begin
      d_vld   <= rd_en;
      d_first <= rd_en && (k_q == '0);
      case (state)
        IDLE: begin
          if (start) begin
            rows_q  <= rows;
            inner_q <= inner;
            cols_q  <= cols;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            busy    <= 1'b1;
            if (rows == '0 || inner == '0 || cols == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              rd_en <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_k) begin
            state <= LAST;
            rd_en <= 1'b0;
          end else begin
            k_q <= k_q + DIM_W'(1);
          end
        end
        LAST: begin
          state    <= WRITE;
          wr_valid <= 1'b1;
          wr_mask  <= mask_nxt;
        end
        WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            k_q      <= '0;
            if (c_adv >= {1'b0, cols_q}) begin
              c_q <= '0;
              r_q <= r_q + DIM_W'(1);
              if (last_row) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= ISSUE;
                rd_en <= 1'b1;
              end
            end else begin
              c_q   <= c_adv[DIM_W-1:0];
              state <= ISSUE;
              rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The k=0 beat loads instead of adding, so no clear cycle is needed between tiles
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (d_vld) begin
      for (int i = 0; i < LANES; i++)
        acc[i] <= (d_first ? '0 : acc[i]) + prod[i][ACC_W-1:0];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign wr_data[g*ACC_W +: ACC_W] = wr_mask[g] ? acc[g] : '0;
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: memory responder, write collector and
// a plain-arithmetic matrix product model.
module tb_matmul_engine;
  localparam int DW = 32, AW = 32, L = 4, DMW = 5;

  logic              CLOCK_25 = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [DMW-1:0]    rows = '0, inner = '0, cols = '0;
  logic              busy, done, rd_en, wr_valid;
  logic [DMW-1:0]    a_row, a_col, b_row, b_col, wr_row, wr_col;
  logic [DW-1:0]     a_data = '0;
  logic [L*DW-1:0]   b_data = '0;
  logic              wr_ready = 1'b1;
  logic [L-1:0]      wr_mask;
  logic [L*AW-1:0]   wr_data;

  matmul_engine #(.DATA_W(DW), .ACC_W(AW), .LANES(L), .DIM_W(DMW)) dut (
    .CLOCK_25(CLOCK_25), .rst_n(rst_n), .start(start),
    .rows(rows), .inner(inner), .cols(cols),
    .busy(busy), .done(done), .rd_en(rd_en),
    .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .a_data(a_data), .b_data(b_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_mask(wr_mask), .wr_data(wr_data)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  typedef struct packed {
    logic [DMW-1:0]  row;
    logic [DMW-1:0]  col;
    logic [L-1:0]    mask;
    logic [L*AW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem_a [32][32];
  logic [DW-1:0] mem_b [32][32];
  wr_t got_q[$];
  wr_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, rd_cnt = 0, wv_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1;
  int unstable = 0, stall_left = 0;
  logic pend = 1'b0;
  logic [DMW-1:0] p_ar, p_ac, p_br, p_bc;
  wr_t prev_w, cur_w;
  logic prev_unacc = 1'b0;

  // Memory responder and write collector, all on the falling edge
  initial forever begin
    @(negedge CLOCK_25);
    cyc++;
    if (rd_en) rd_cnt++;
    if (wr_valid) wv_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (pend) begin
      a_data = mem_a[p_ar][p_ac];
      for (int i = 0; i < L; i++) begin
        int col;
        col = int'(p_bc) + i;
        b_data[i*DW +: DW] = (col < 32) ? mem_b[p_br][col] : '0;
      end
    end
    pend = rd_en;
    p_ar = a_row; p_ac = a_col; p_br = b_row; p_bc = b_col;
    if (wr_valid) begin
      cur_w = {wr_row, wr_col, wr_mask, wr_data};
      if (prev_unacc && cur_w !== prev_w) unstable++;
      prev_w = cur_w;
      if (stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_ready) begin
        got_q.push_back(cur_w);
        prev_unacc = 1'b0;
      end else begin
        prev_unacc = 1'b1;
      end
    end else begin
      wr_ready = 1'b1;
      prev_unacc = 1'b0;
    end
  end

  function automatic void build_model(int m, int k, int n);
    wr_t w;
    logic [AW-1:0] s;
    exp_q.delete();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c += L) begin
        w.row = DMW'(r);
        w.col = DMW'(c);
        w.mask = '0;
        w.data = '0;
        for (int i = 0; i < L; i++)
          if (c + i < n) begin
            s = '0;
            for (int kk = 0; kk < k; kk++)
              s = s + AW'(64'(mem_a[r][kk]) * 64'(mem_b[kk][c+i]));
            w.mask[i] = 1'b1;
            w.data[i*AW +: AW] = s;
          end
        exp_q.push_back(w);
      end
  endfunction

  function automatic int exp_cycles(int m, int k, int n, int stall);
    if (m == 0 || k == 0 || n == 0) return 1;
    return ((n + L - 1) / L) * m * (k + 2) + 1 + stall;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        mem_a[i][j] = $urandom;
        mem_b[i][j] = $urandom;
      end
  endtask

  task automatic load_small();
    fill_rand();
    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
  endtask

  task automatic clear_counts();
    cyc = 0; rd_cnt = 0; wv_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    unstable = 0; prev_unacc = 1'b0;
    got_q.delete();
  endtask

  // Starts a job and waits (bounded) for done; optionally pokes start/dims mid-job
  task automatic run_job(int m, int k, int n, bit disturb);
    @(negedge CLOCK_25);
    #1;
    rows = DMW'(m); inner = DMW'(k); cols = DMW'(n); start = 1'b1;
    @(posedge CLOCK_25);
    #1;
    start = 1'b0;
    clear_counts();
    for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
      @(negedge CLOCK_25);
      #1;
      if (disturb && t == 2) begin
        start = 1'b1;
        rows = DMW'($urandom_range(1, 7));
        inner = DMW'($urandom_range(0, 7));
        cols = DMW'($urandom_range(1, 12));
      end else if (disturb && t == 3) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge CLOCK_25);
    #1;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_valid, a_row, a_col, b_row, b_col, wr_row, wr_col, wr_mask, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_valid=%b mask=%b data=%h, required all zero",
               busy, done, rd_en, wr_valid, wr_mask, wr_data);
    end
    repeat (2) @(negedge CLOCK_25);
    rst_n = 1'b1;
    clear_counts();
    repeat (4) @(negedge CLOCK_25);
    #1;
    checks++;
    if (busy_cnt != 0 || done_cnt != 0 || rd_cnt != 0) begin
      failures++;
      $display("FAIL reset_idle: busy_cnt=%0d done_cnt=%0d rd_cnt=%0d, required 0/0/0", busy_cnt, done_cnt, rd_cnt);
    end
  endtask

  task automatic test_basic();
    logic [L*AW-1:0] e0, e1;
    load_small();
    run_job(2, 2, 2, 0);
    e0 = {32'd0, 32'd0, 32'd22, 32'd19};
    e1 = {32'd0, 32'd0, 32'd50, 32'd43};
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL basic_count: got %0d writes, required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {5'd0, 5'd0, 4'b0011, e0}) begin
        failures++;
        $display("FAIL basic_w0: got row=%0d col=%0d mask=%b data=%h", got_q[0].row, got_q[0].col, got_q[0].mask, got_q[0].data);
      end
      checks++;
      if (got_q[1] !== {5'd1, 5'd0, 4'b0011, e1}) begin
        failures++;
        $display("FAIL basic_w1: got row=%0d col=%0d mask=%b data=%h", got_q[1].row, got_q[1].col, got_q[1].mask, got_q[1].data);
      end
    end
    checks++;
    if (done_cyc != 9) begin
      failures++;
      $display("FAIL basic_done_cycle: got %0d, required 9", done_cyc);
    end
    checks++;
    if (rd_cnt != 4 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_rd_done: rd_cnt=%0d done_cnt=%0d, required 4 and 1", rd_cnt, done_cnt);
    end
  endtask

  task automatic test_partial();
    fill_rand();
    run_job(1, 3, 6, 0);
    build_model(1, 3, 6);
    checks++;
    if (rd_cnt != 6) begin
      failures++;
      $display("FAIL partial_rd_cnt: got %0d, required 6", rd_cnt);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL partial_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL partial_w%0d: got col=%0d mask=%b data=%h, required col=%0d mask=%b data=%h",
                   i, got_q[i].col, got_q[i].mask, got_q[i].data, exp_q[i].col, exp_q[i].mask, exp_q[i].data);
        end
      end
      checks++;
      if (got_q[1].mask !== 4'b0011 || got_q[1].data[2*AW +: 2*AW] !== '0) begin
        failures++;
        $display("FAIL partial_tail: mask=%b upper=%h, required 0011 and zero", got_q[1].mask, got_q[1].data[2*AW +: 2*AW]);
      end
    end
    checks++;
    if (done_cyc != exp_cycles(1, 3, 6, 0)) begin
      failures++;
      $display("FAIL partial_done_cycle: got %0d, required %0d", done_cyc, exp_cycles(1, 3, 6, 0));
    end
  endtask

  task automatic test_zero_dims();
    int dims [3][3] = '{'{2, 0, 3}, '{0, 2, 2}, '{3, 3, 0}};
    fill_rand();
    for (int i = 0; i < 3; i++) begin
      run_job(dims[i][0], dims[i][1], dims[i][2], 0);
      checks++;
      if (done_cyc != 1 || rd_cnt != 0 || wv_cnt != 0 || got_q.size() != 0 || done_cnt != 1) begin
        failures++;
        $display("FAIL zero_dim_%0d: done_cyc=%0d rd_cnt=%0d wv_cnt=%0d writes=%0d done_cnt=%0d, required 1/0/0/0/1",
                 i, done_cyc, rd_cnt, wv_cnt, got_q.size(), done_cnt);
      end
    end
  endtask

  task automatic test_stall();
    load_small();
    stall_left = 5;
    run_job(2, 2, 2, 0);
    build_model(2, 2, 2);
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL stall_stable: %0d changes while waiting, required 0", unstable);
    end
    checks++;
    if (wv_cnt != 7) begin
      failures++;
      $display("FAIL stall_valid_cycles: got %0d, required 7", wv_cnt);
    end
    checks++;
    if (done_cyc != 14) begin
      failures++;
      $display("FAIL stall_done_cycle: got %0d, required 14", done_cyc);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stall_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL stall_w%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        mem_a[i][j] = 32'hFFFF_FFFF;
        mem_b[i][j] = 32'hFFFF_FFFF;
      end
    run_job(1, 2, 4, 0);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL overflow_count: got %0d writes, required 1", got_q.size());
    end else begin
      for (int i = 0; i < L; i++) begin
        checks++;
        if (got_q[0].data[i*AW +: AW] !== 32'd2) begin
          failures++;
          $display("FAIL overflow_lane%0d: got %h, required 00000002", i, got_q[0].data[i*AW +: AW]);
        end
      end
    end
  endtask

  task automatic test_random();
    int m, k, n, st;
    for (int it = 0; it < 6; it++) begin
      fill_rand();
      m = $urandom_range(1, 3);
      k = $urandom_range(1, 5);
      n = $urandom_range(1, 9);
      st = $urandom_range(0, 3);
      stall_left = st;
      run_job(m, k, n, 0);
      build_model(m, k, n);
      checks++;
      if (done_cyc != exp_cycles(m, k, n, st) || rd_cnt != ((n + L - 1) / L) * m * k) begin
        failures++;
        $display("FAIL random_%0d_timing: dims %0d/%0d/%0d done_cyc=%0d rd_cnt=%0d, required %0d and %0d",
                 it, m, k, n, done_cyc, rd_cnt, exp_cycles(m, k, n, st), ((n + L - 1) / L) * m * k);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random_%0d_count: got %0d, required %0d", it, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_%0d_w%0d: got %h, required %h", it, i, got_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    fill_rand();
    run_job(2, 3, 5, 1);
    build_model(2, 3, 5);
    checks++;
    if (done_cyc != exp_cycles(2, 3, 5, 0) || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_ignore_timing: done_cyc=%0d done_cnt=%0d, required %0d and 1", done_cyc, done_cnt, exp_cycles(2, 3, 5, 0));
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL busy_ignore_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL busy_ignore_w%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    load_small();
    @(negedge CLOCK_25);
    #1;
    rows = 2; inner = 2; cols = 2; start = 1'b1;
    @(posedge CLOCK_25);
    #1;
    start = 1'b0;
    @(posedge CLOCK_25);
    #2;
    checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: rd_en=%b busy=%b, required 1/1", rd_en, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, wr_valid, a_row, a_col, b_row, b_col, wr_row, wr_col, wr_mask, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: busy=%b rd_en=%b a_col=%0d mask=%b data=%h, required all zero",
               busy, rd_en, a_col, wr_mask, wr_data);
    end
    repeat (2) @(negedge CLOCK_25);
    rst_n = 1'b1;
    clear_counts();
    repeat (12) @(negedge CLOCK_25);
    #1;
    checks++;
    if (busy_cnt != 0 || wv_cnt != 0 || rd_cnt != 0 || got_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_idle: busy_cnt=%0d wv_cnt=%0d rd_cnt=%0d writes=%0d, required all 0",
               busy_cnt, wv_cnt, rd_cnt, got_q.size());
    end
    run_job(2, 2, 2, 0);
    build_model(2, 2, 2);
    checks++;
    if (done_cyc != 9 || got_q.size() != 2) begin
      failures++;
      $display("FAIL reset_mid_rerun: done_cyc=%0d writes=%0d, required 9 and 2", done_cyc, got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL reset_mid_w%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_zero_dims();
    test_stall();
    test_overflow();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, operand width; ACC_W, default 32, accumulator/result width; LANES, default 4, number of parallel MAC lanes (one output column each); DIM_W, default 5, width of each dimension field (max dimension 2^DIM_W-1).
REQ-002 SHALL have ports (name  direction  width  meaning):
 CLOCK_25  in  1  single clock, rising edge.
 rst_n  in  1  asynchronous, active-low reset.
 start  in  1  start request, sampled only in IDLE.
 rows, inner, cols  in  DIM_W each  M, K, N of C[MxN] = A[MxK] * B[KxN].
 busy  out  1  high from the cycle after an accepted start until done.
 done  out  1  one-cycle completion pulse.
 rd_en  out  1  operand read strobe.
 a_row, a_col  out  DIM_W each  A element address (r, k).
 b_row, b_col  out  DIM_W each  B vector address (k, c); the memory returns B[k][c+i] on lane i.
 a_data  in  DATA_W  A[r][k], valid exactly one cycle after rd_en.
 b_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], same 1-cycle latency.
 wr_valid  out  1  result tile valid.
 wr_ready  in  1  result sink accepts when wr_valid and wr_ready are both high.
 wr_row, wr_col  out  DIM_W each  C row r and base column c of the tile.
 wr_mask  out  LANES  bit i high iff c+i < cols.
 wr_data  out  LANES*ACC_W  lane i = C[r][c+i], or 0 where the mask bit is low.

Function
REQ-003 SHALL implement states IDLE, ISSUE, LAST, WRITE, DONE.
REQ-004 IDLE: on start=1, SHALL latch rows/inner/cols; if any latched dimension is 0, SHALL go to DONE and perform no reads or writes; otherwise SHALL go to ISSUE with r=0, c=0, k=0.
REQ-005 ISSUE: SHALL assert rd_en with a=(r,k) and b=(k,c) for k=0..inner-1 on consecutive cycles, one k per cycle; after k=inner-1 SHALL go to LAST.
REQ-006 Each lane SHALL load acc_i = a*b_i on the data cycle of k=0 and set acc_i = acc_i + a*b_i on later data cycles; no separate clear cycle is used.
REQ-007 LAST: SHALL absorb the final data beat with rd_en low, then go to WRITE.
REQ-008 WRITE: SHALL hold wr_valid and all wr_* fields stable until wr_ready=1; on acceptance SHALL advance c by LANES; if the new c >= cols, SHALL set c=0 and increment r; if r then equals rows, SHALL go to DONE, else to ISSUE with k=0.
REQ-009 DONE: SHALL pulse done=1 for one cycle, then go to IDLE; busy SHALL be high in ISSUE, LAST, WRITE and DONE.
REQ-010 Products SHALL be unsigned DATA_W x DATA_W; the sum SHALL be truncated to ACC_W bits (modulo 2^ACC_W wrap, no saturation, no overflow flag).
REQ-011 Partial final tile: lanes with c+i >= cols SHALL still accumulate but SHALL drive 0 on wr_data, with their wr_mask bit low.
REQ-012 start while busy SHALL be ignored; a dimension change while busy SHALL have no effect.
REQ-013 With wr_ready held high, a tile SHALL take inner+2 cycles; a job SHALL take ceil(cols/LANES)*rows*(inner+2)+1 cycles from the start edge to the done pulse inclusive.
REQ-014 rd_en SHALL be low in every state except ISSUE, and wr_valid SHALL be low in every state except WRITE.

Reset
REQ-015 rst_n=0 SHALL immediately, without a clock edge, force the state to IDLE and drive busy, done, rd_en and wr_valid to 0, and all address fields, wr_mask, wr_data and accumulators to 0.
REQ-016 Reset asserted mid-job SHALL abandon the job; after release the block SHALL idle until a new start, and no write from the old job SHALL appear.

Verification
REQ-017 LANES=4, A=[[1,2],[3,4]], B=[[5,6],[7,8]], dims 2/2/2, wr_ready=1 -> two writes: (0,0) mask 0011 data {0,0,22,19}; (1,0) mask 0011 data {0,0,50,43}; done on cycle 9.
REQ-018 dims 1/3/6, LANES=4 -> tiles at c=0 (mask 1111) and c=4 (mask 0011, upper lanes 0); rd_en high on exactly 6 cycles.
REQ-019 inner=0 -> done one cycle after start; rd_en and wr_valid never asserted.
REQ-020 wr_ready held low for 5 cycles during the first WRITE -> wr_* fields stable for all 6 cycles; done is delayed by 5 cycles; results unchanged.
REQ-021 A=B=all 0xFFFFFFFF, inner=2 -> each lane = 2 (low 32 bits of 2*(2^32-1)^2).
REQ-022 rst_n pulsed low during ISSUE -> all outputs 0 asynchronously; a new start then runs the REQ-017 job correctly.
